mem_read_arbiter: RTL

//   Shares the single 64-bit combinational memory read port (nmem_read-style DPI memory)

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_grant.sv | 48 ++++
 rtl/mem_read_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory read arbiter.
//   gnt_e        : which requester owns the read port this cycle
//   NOP_INST_DEF : default instruction returned when no IF response is valid
//   word_sel     : picks the 32-bit instruction word out of a 64-bit beat
package mem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LS   = 2'd2
    } gnt_e;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // Address bit 2 selects the upper word of the 8-byte beat.
    function automatic logic [31:0] word_sel(input logic [63:0] beat, input logic sel);
        logic [31:0] word;
        if (sel) begin
            word = beat[63:32];
        end else begin
            word = beat[31:0];
        end
        return word;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational grant decode for the shared memory read port.
// Ports:
//   inhibit      in  : forces no grant (held high while the block is in reset)
//   if_req_valid in  : IF request
//   if_flush     in  : IF flush; an IF request seen with flush is not granted
//   ls_req_valid in  : LS request
//   starve_cnt   in  : consecutive LS grants taken while IF was waiting
//   gnt          out : GNT_NONE / GNT_IF / GNT_LS
module mem_arb_grant
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             inhibit,
    input  logic             if_req_valid,
    input  logic             if_flush,
    input  logic             ls_req_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    output gnt_e             gnt
);

    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    logic if_elig_s;

    // LS wins ties unless IF has been passed over STARVE_MAX times in a row.
    always_comb begin
        gnt       = GNT_NONE;
        if_elig_s = if_req_valid & ~if_flush;
        if (inhibit) begin
            gnt = GNT_NONE;
        end else if (if_elig_s && ls_req_valid) begin
            if (starve_cnt == STARVE_LIMIT) begin
                gnt = GNT_IF;
            end else begin
                gnt = GNT_LS;
            end
        end else if (if_elig_s) begin
            gnt = GNT_IF;
        end else if (ls_req_valid) begin
            gnt = GNT_LS;
        end else begin
            gnt = GNT_NONE;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one combinational 64-bit memory read port between instruction fetch
// (IF) and load/store (LS). One grant per cycle, LS has priority, IF is forced
// through after STARVE_MAX consecutive LS wins. Responses appear one cycle
// after the grant.
// Ports:
//   clock, reset                : clock, asynchronous active-high reset
//   if_req_valid/addr/ready     : IF request handshake (ready == grant)
//   if_flush                    : blocks an IF grant this cycle and drops the
//                                 IF response presented this cycle
//   if_resp_valid/inst/misal    : IF response (inst = NOP_INST when not valid)
//   ls_req_valid/addr/ready     : LS request handshake (ready == grant)
//   ls_resp_valid/data          : LS response (data holds last beat)
//   mem_en/mem_addr/mem_rdata   : memory read port, data valid same cycle
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W     = 64,
    parameter int          DATA_W     = 64,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEF,
    parameter int          STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [31:0]       if_resp_inst,
    output logic              if_resp_misal,
    input  logic              ls_req_valid,
    input  logic [ADDR_W-1:0] ls_req_addr,
    output logic              ls_req_ready,
    output logic              ls_resp_valid,
    output logic [DATA_W-1:0] ls_resp_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W        = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    gnt_e              gnt_s;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic [CNT_W-1:0]  starve_nxt_s;
    logic              if_pend_r;
    logic [31:0]       if_inst_r;
    logic              if_misal_r;
    logic              ls_pend_r;
    logic [DATA_W-1:0] ls_data_r;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_grant (
        .inhibit      (reset),
        .if_req_valid (if_req_valid),
        .if_flush     (if_flush),
        .ls_req_valid (ls_req_valid),
        .starve_cnt   (starve_cnt_r),
        .gnt          (gnt_s)
    );

    // Handshake and memory port driven straight from the grant.
    always_comb begin
        if_req_ready = 1'b0;
        ls_req_ready = 1'b0;
        mem_en       = 1'b0;
        mem_addr     = '0;
        case (gnt_s)
            GNT_IF: begin
                if_req_ready = 1'b1;
                mem_en       = 1'b1;
                mem_addr     = if_req_addr;
            end
            GNT_LS: begin
                ls_req_ready = 1'b1;
                mem_en       = 1'b1;
                mem_addr     = ls_req_addr;
            end
            default: begin
                if_req_ready = 1'b0;
                ls_req_ready = 1'b0;
                mem_en       = 1'b0;
                mem_addr     = '0;
            end
        endcase
    end

    // A flush arriving in the response cycle kills the IF response on the spot.
    always_comb begin
        if_resp_valid = if_pend_r & ~if_flush;
        if_resp_misal = if_misal_r & if_resp_valid;
        if (if_resp_valid) begin
            if_resp_inst = if_inst_r;
        end else begin
            if_resp_inst = NOP_INST;
        end
        ls_resp_valid = ls_pend_r;
        ls_resp_data  = ls_data_r;
    end

    // Starvation count: tracks LS wins while an unflushed IF request waits.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if ((gnt_s == GNT_IF) || !if_req_valid) begin
            starve_nxt_s = '0;
        end else if ((gnt_s == GNT_LS) && !if_flush && (starve_cnt_r != STARVE_LIMIT)) begin
            starve_nxt_s = starve_cnt_r + CNT_W'(1);
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Response capture and arbitration state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= '0;
            if_pend_r    <= 1'b0;
            if_inst_r    <= NOP_INST;
            if_misal_r   <= 1'b0;
            ls_pend_r    <= 1'b0;
            ls_data_r    <= '0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
            if_pend_r    <= (gnt_s == GNT_IF);
            ls_pend_r    <= (gnt_s == GNT_LS);
            if (gnt_s == GNT_IF) begin
                if_inst_r  <= word_sel(mem_rdata, if_req_addr[2]);
                if_misal_r <= (if_req_addr[1:0] != 2'b00);
            end
            if (gnt_s == GNT_LS) begin
                ls_data_r <= mem_rdata;
            end
        end
    end

endmodule
